// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan multiplexer.
// Patterns are active-high in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] hex2seg(
    input logic [3:0] n
  );
    logic [6:0] s;
    s = '0;
    unique case (n)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_sync.sv
// Two-flop synchroniser plus history flop; pulses on rising edges.
// Reusable for any slow asynchronous level such as a button.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes hex digits onto a shared 7-segment bus, stepping
// on each rising edge of a slow divided clock with optional blank gaps.
module seg7_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_STEPS = 1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          div_clk,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);
  import seg7_pkg::*;

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (BLANK_STEPS > 1) ? $clog2(BLANK_STEPS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((BLANK_STEPS > 0) ? BLANK_STEPS - 1 : 0);
  localparam logic POL = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};
  localparam logic [6:0] SEG_OFF = {7{POL}};

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  step;
  logic                  wrap;
  logic [IW-1:0]         idx_inc;
  logic [IW-1:0]         ld_idx;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] hot;
  logic [NUM_DIGITS-1:0] an_ld;
  logic [6:0]            seg_ld;
  logic                  dp_ld;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (div_clk),
    .rise_o (step)
  );

  // Slot contents for whichever digit is about to be shown.
  always_comb begin
    wrap    = (idx_q == IDX_LAST);
    idx_inc = wrap ? '0 : idx_q + 1'b1;
    ld_idx  = (state_q == SHOW) ? idx_inc : idx_q;
    nib     = digits[{ld_idx, 2'b00} +: 4];
    hot     = blank_mask[ld_idx] ? '0
            : NUM_DIGITS'(1) << ld_idx;
    an_ld   = AN_OFF ^ hot;
    seg_ld  = SEG_OFF ^ hex2seg(nib);
    dp_ld   = POL ^ dp[ld_idx];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    fd_d    = 1'b0;
    if (step) begin
      unique case (state_q)
        BLANK: begin
          if (BLANK_STEPS == 0 || cnt_q == CNT_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            an_d    = an_ld;
            seg_d   = seg_ld;
            dp_d    = dp_ld;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          idx_d = idx_inc;
          fd_d  = wrap;
          if (BLANK_STEPS == 0) begin
            an_d  = an_ld;
            seg_d = seg_ld;
            dp_d  = dp_ld;
          end else begin
            state_d = BLANK;
            an_d    = AN_OFF;
            seg_d   = SEG_OFF;
            dp_d    = POL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= POL;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_out     = dp_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench: three scan muxes (1, 0 and 2 blank steps) share
// one stimulus; expectations come from step-count arithmetic.
module tb_seg7_scan_mux;

  typedef struct {
    int         due;
    int         inst;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic [1:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_clk = 1'b0;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  mask;

  logic [3:0] an_w  [3];
  logic [6:0] seg_w [3];
  logic       dpo_w [3];
  logic       fd_w  [3];
  logic [1:0] idx_w [3];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   t = 0;
  exp_t q[$];
  exp_t cur[3];

  logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seg7_scan_mux #(
    .NUM_DIGITS(4), .BLANK_STEPS(1), .ACTIVE_LOW(1'b1)
  ) u_b1 (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .digits(digits), .dp(dp), .blank_mask(mask),
    .an(an_w[0]), .seg(seg_w[0]), .dp_out(dpo_w[0]),
    .digit_idx(idx_w[0]), .frame_done(fd_w[0])
  );

  seg7_scan_mux #(
    .NUM_DIGITS(4), .BLANK_STEPS(0), .ACTIVE_LOW(1'b1)
  ) u_b0 (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .digits(digits), .dp(dp), .blank_mask(mask),
    .an(an_w[1]), .seg(seg_w[1]), .dp_out(dpo_w[1]),
    .digit_idx(idx_w[1]), .frame_done(fd_w[1])
  );

  seg7_scan_mux #(
    .NUM_DIGITS(4), .BLANK_STEPS(2), .ACTIVE_LOW(1'b1)
  ) u_b2 (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .digits(digits), .dp(dp), .blank_mask(mask),
    .an(an_w[2]), .seg(seg_w[2]), .dp_out(dpo_w[2]),
    .digit_idx(idx_w[2]), .frame_done(fd_w[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t reset_exp(int inst);
    exp_t e;
    e.due  = 0;
    e.inst = inst;
    e.an   = 4'hF;
    e.seg  = 7'h7F;
    e.dp   = 1'b1;
    e.fd   = 1'b0;
    e.idx  = 2'd0;
    return e;
  endfunction

  // Outputs after tt steps since reset: first show at step max(B,1),
  // then one show every B+1 steps, digits in order 0..3.
  function automatic exp_t model(int inst, int tt);
    exp_t e;
    int   b, p, f, d;
    bit   show;
    b = (inst == 0) ? 1 : (inst == 1) ? 0 : 2;
    p = b + 1;
    f = (b > 0) ? b : 1;
    show = (tt >= f) && ((tt - f) % p == 0);
    d = show ? ((tt - f) / p) % 4 : 0;
    e.due  = 0;
    e.inst = inst;
    e.an   = (show && !mask[d]) ? 4'(~(4'b0001 << d)) : 4'hF;
    e.seg  = show ? ~lut[digits[d*4 +: 4]] : 7'h7F;
    e.dp   = show ? ~dp[d] : 1'b1;
    if (show)
      e.idx = 2'(d);
    else if (tt < f)
      e.idx = 2'd0;
    else
      e.idx = 2'(((tt - f) / p + 1) % 4);
    e.fd = (tt - 1 >= f) && ((tt - 1 - f) % p == 0)
        && (((tt - 1 - f) / p) % 4 == 3);
    return e;
  endfunction

  task automatic check_out(input int i, input exp_t e, input string tag);
    checks++;
    if (an_w[i] !== e.an || seg_w[i] !== e.seg || dpo_w[i] !== e.dp
        || fd_w[i] !== e.fd || idx_w[i] !== e.idx) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got an=%h seg=%h dp=%b fd=%b idx=%0d exp an=%h seg=%h dp=%b fd=%b idx=%0d",
        tag, i, cyc, an_w[i], seg_w[i], dpo_w[i], fd_w[i], idx_w[i],
        e.an, e.seg, e.dp, e.fd, e.idx);
    end
  endtask

  // Monitor: applies expectations on their due cycle, checks every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) cur[i] = reset_exp(i);
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        cur[e.inst] = e;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check_out(i, cur[i], "scan");
      cur[i].fd = 1'b0;
    end
  end

  task automatic do_step(input int hold, input bit perturb);
    exp_t e;
    @(posedge clk);
    #1;
    div_clk = 1'b1;
    t++;
    for (int i = 0; i < 3; i++) begin
      e = model(i, t);
      e.due = cyc + 3;
      q.push_back(e);
    end
    repeat (3) @(posedge clk);
    #1;
    if (perturb) begin
      digits = 16'($urandom);
      dp     = 4'($urandom);
      mask   = 4'($urandom);
    end
    repeat (hold) @(posedge clk);
    #1;
    div_clk = 1'b0;
    repeat ($urandom_range(3, 6)) @(posedge clk);
  endtask

  initial begin
    int guard;
    digits = 16'h1234;
    dp     = 4'h0;
    mask   = 4'h0;
    #32;
    rst_n = 1'b1;

    repeat (8) do_step(2, 1'b0);
    do_step(20, 1'b0);

    mask = 4'b0100;
    dp   = 4'b0001;
    repeat (8) do_step(2, 1'b0);

    repeat (40) do_step($urandom_range(1, 5), 1'b1);

    guard = 0;
    while (!((t % 2 == 1) && (((t - 1) / 2) % 4 == 2)) && guard < 16) begin
      do_step(2, 1'b1);
      guard++;
    end
    checks++;
    if (guard >= 16) begin
      failures++;
      $display("FAIL reach_digit2 got t=%0d exp show of digit 2", t);
    end

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_out(i, reset_exp(i), "async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    t = 0;

    repeat (10) do_step(2, 1'b1);
    repeat (5) @(posedge clk);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
